// File: rtl/map_ss_seq_pkg.sv
// Shared definitions for the mapper save-state sequencer: FSM state encoding
// and the ss_addr that returns the mapper index.
package map_ss_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_D_ADDR = 3'd1;
    localparam state_t ST_D_SEND = 3'd2;
    localparam state_t ST_R_HDR  = 3'd3;
    localparam state_t ST_R_DATA = 3'd4;
    localparam state_t ST_R_WR   = 3'd5;
    localparam state_t ST_FIN    = 3'd6;

    localparam int SS_IDX_ADDR = 127;

endpackage

// File: rtl/map_ss_seq.sv
// Save-state sequencer: dumps a mapper's index and registers as a byte stream,
// or restores them from a stream after checking the header against the loaded mapper.
module map_ss_seq
    import map_ss_seq_pkg::*;
#(
    parameter int REG_CNT  = 3,
    parameter int IDX_ADDR = SS_IDX_ADDR
) (
    input  logic       clk,
    input  logic       map_rst,
    input  logic       cmd_dump,
    input  logic       cmd_rest,
    input  logic [7:0] map_idx_exp,
    output logic       ss_act,
    output logic [7:0] ss_addr,
    output logic       ss_we,
    output logic [7:0] ss_wdat,
    input  logic [7:0] ss_rdat,
    output logic [7:0] st_dat,
    output logic       st_vld,
    input  logic       st_rdy,
    input  logic [7:0] ld_dat,
    input  logic       ld_vld,
    output logic       ld_rdy,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [7:0] LAST_PTR = 8'(REG_CNT - 1);
    localparam logic [7:0] IDX_PTR  = 8'(IDX_ADDR);

    state_t     state, state_nxt;
    logic [7:0] ptr, ptr_nxt;
    logic       cmd_acc;
    logic       hdr_bad;

    assign cmd_acc = (state == ST_IDLE) && (cmd_dump || cmd_rest);
    assign hdr_bad = (state == ST_R_HDR) && ld_vld && (ld_dat != map_idx_exp);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            ST_IDLE: begin
                if (cmd_dump) begin
                    state_nxt = ST_D_ADDR;
                    ptr_nxt   = IDX_PTR;
                end else if (cmd_rest) begin
                    state_nxt = ST_R_HDR;
                end
            end
            ST_D_ADDR: state_nxt = ST_D_SEND;
            ST_D_SEND: begin
                if (st_rdy) begin
                    // The header byte is sent first, then registers 0..REG_CNT-1.
                    if (ptr == IDX_PTR) begin
                        ptr_nxt   = 8'd0;
                        state_nxt = ST_D_ADDR;
                    end else if (ptr == LAST_PTR) begin
                        state_nxt = ST_FIN;
                    end else begin
                        ptr_nxt   = ptr + 8'd1;
                        state_nxt = ST_D_ADDR;
                    end
                end
            end
            ST_R_HDR: begin
                if (ld_vld) begin
                    if (ld_dat == map_idx_exp) begin
                        ptr_nxt   = 8'd0;
                        state_nxt = ST_R_DATA;
                    end else begin
                        state_nxt = ST_FIN;
                    end
                end
            end
            ST_R_DATA: if (ld_vld) state_nxt = ST_R_WR;
            ST_R_WR: begin
                if (ptr == LAST_PTR) begin
                    state_nxt = ST_FIN;
                end else begin
                    ptr_nxt   = ptr + 8'd1;
                    state_nxt = ST_R_DATA;
                end
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            state   <= ST_IDLE;
            ptr     <= 8'd0;
            st_dat  <= 8'd0;
            ss_wdat <= 8'd0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            if (state == ST_D_ADDR)
                st_dat <= ss_rdat;
            if (state == ST_R_DATA && ld_vld)
                ss_wdat <= ld_dat;
            if (cmd_acc)
                err <= 1'b0;
            else if (hdr_bad)
                err <= 1'b1;
        end
    end

    assign busy    = (state != ST_IDLE);
    assign ss_act  = busy;
    assign ss_addr = ptr;
    assign ss_we   = (state == ST_R_WR);
    assign st_vld  = (state == ST_D_SEND);
    assign ld_rdy  = (state == ST_R_HDR) || (state == ST_R_DATA);
    assign done    = (state == ST_FIN);

endmodule

// File: tb/tb_map_ss_seq.sv
// Self-checking bench for map_ss_seq: directed dump/restore scenarios plus
// randomized operations checked against a stream-level reference model.
module tb_map_ss_seq;

    localparam int REG_CNT = 3;
    localparam int IDX     = 127;

    logic       clk = 1'b0;
    logic       map_rst, cmd_dump, cmd_rest;
    logic [7:0] map_idx_exp;
    logic       ss_act, ss_we, st_vld, st_rdy, ld_vld, ld_rdy, busy, done, err;
    logic [7:0] ss_addr, ss_wdat, ss_rdat, st_dat, ld_dat;

    map_ss_seq #(.REG_CNT(REG_CNT), .IDX_ADDR(IDX)) dut (
        .clk(clk), .map_rst(map_rst), .cmd_dump(cmd_dump), .cmd_rest(cmd_rest),
        .map_idx_exp(map_idx_exp), .ss_act(ss_act), .ss_addr(ss_addr), .ss_we(ss_we),
        .ss_wdat(ss_wdat), .ss_rdat(ss_rdat), .st_dat(st_dat), .st_vld(st_vld),
        .st_rdy(st_rdy), .ld_dat(ld_dat), .ld_vld(ld_vld), .ld_rdy(ld_rdy),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Mapper model and stream bookkeeping
    logic [7:0]  mem [256];
    logic [7:0]  ld_arr [256];
    int          ld_len = 0, consumed = 0;
    logic [7:0]  st_q [$];
    logic [15:0] wr_q [$];
    int          viol = 0, hold_err = 0, rdy_cnt = 0;
    logic        held = 1'b0;
    logic [7:0]  held_val = 8'd0;
    int          rdy_mode = 0, rdy_phase = 0;
    bit          vld_rand = 1'b0;
    int          n_tests = 0, n_fail = 0;

    assign ss_rdat = mem[ss_addr];

    always @(posedge clk) begin
        if (ss_we) begin
            mem[ss_addr] = ss_wdat;
            wr_q.push_back({ss_addr, ss_wdat});
        end
        if (st_vld && st_rdy) st_q.push_back(st_dat);
        if (ld_vld && ld_rdy) consumed = consumed + 1;
        if (ld_rdy) rdy_cnt = rdy_cnt + 1;
        if ((ss_we && !ss_act) || (ld_rdy && (ss_we || done))) viol = viol + 1;
        if (held && (!st_vld || st_dat != held_val)) hold_err = hold_err + 1;
        held     = st_vld && !st_rdy;
        held_val = st_dat;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        rdy_phase = (rdy_phase + 1) % 3;
        case (rdy_mode)
            0:       st_rdy = 1'b1;
            1:       st_rdy = (rdy_phase == 0);
            default: st_rdy = 1'($urandom_range(0, 1));
        endcase
        if (consumed < ld_len) begin
            ld_vld = vld_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            ld_dat = ld_arr[consumed];
        end else begin
            ld_vld = 1'b0;
            ld_dat = 8'($urandom);
        end
    endtask

    task automatic start(input logic d, input logic r);
        cmd_dump = d;
        cmd_rest = r;
        tick();
        cmd_dump = 1'b0;
        cmd_rest = 1'b0;
        check("act_after_cmd", ss_act, 1'b1);
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_act"},   ss_act,  1'b0);
        check({tag, "_we"},    ss_we,   1'b0);
        check({tag, "_addr"},  ss_addr, 8'd0);
        check({tag, "_wdat"},  ss_wdat, 8'd0);
        check({tag, "_stvld"}, st_vld,  1'b0);
        check({tag, "_stdat"}, st_dat,  8'd0);
        check({tag, "_ldrdy"}, ld_rdy,  1'b0);
        check({tag, "_busy"},  busy,    1'b0);
        check({tag, "_done"},  done,    1'b0);
        check({tag, "_err"},   err,     1'b0);
    endtask

    // Expected dump: header = mem[IDX], then registers 0..REG_CNT-1, no writes.
    task automatic run_dump(input string tag, input int exp_cyc, input logic both);
        logic [7:0] exp_s [$];
        int n;
        exp_s.push_back(mem[IDX]);
        for (int i = 0; i < REG_CNT; i++) exp_s.push_back(mem[i]);
        st_q.delete();
        wr_q.delete();
        hold_err = 0;
        start(1'b1, both);
        check({tag, "_err_clr"}, err, 1'b0);
        wait_done(n);
        if (exp_cyc > 0) check({tag, "_cycles"}, n, exp_cyc);
        check({tag, "_len"}, st_q.size(), exp_s.size());
        for (int i = 0; i < exp_s.size() && i < st_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), st_q[i], exp_s[i]);
        check({tag, "_no_we"}, wr_q.size(), 0);
        check({tag, "_hold"}, hold_err, 0);
        check({tag, "_err"}, err, 1'b0);
        tick();
    endtask

    // Expected restore: matching header writes every register in order; a
    // mismatch consumes one byte, writes nothing and flags err.
    task automatic run_rest(input string tag, input logic [7:0] hdr, input logic [7:0] exp_idx,
                            input int exp_cyc);
        bit match;
        int n;
        match = (hdr == exp_idx);
        map_idx_exp = exp_idx;
        ld_arr[0] = hdr;
        for (int i = 1; i <= REG_CNT; i++) ld_arr[i] = 8'($urandom);
        wr_q.delete();
        consumed = 0;
        ld_len = REG_CNT + 1;
        start(1'b0, 1'b1);
        wait_done(n);
        if (exp_cyc > 0) check({tag, "_cycles"}, n, exp_cyc);
        check({tag, "_err"}, err, !match);
        check({tag, "_ldrdy_fin"}, ld_rdy, 1'b0);
        tick();
        check({tag, "_consumed"}, consumed, match ? REG_CNT + 1 : 1);
        check({tag, "_nwr"}, wr_q.size(), match ? REG_CNT : 0);
        for (int i = 0; i < wr_q.size() && match; i++)
            check($sformatf("%s_wr%0d", tag, i), wr_q[i], {8'(i), ld_arr[i + 1]});
        check({tag, "_err_sticky"}, err, !match);
        ld_len = 0;
    endtask

    initial begin
        int n;
        map_rst = 1'b1; cmd_dump = 1'b0; cmd_rest = 1'b0; map_idx_exp = 8'h22;
        st_rdy = 1'b1; ld_vld = 1'b0; ld_dat = 8'd0;
        for (int i = 0; i < 256; i++) begin mem[i] = 8'd0; ld_arr[i] = 8'd0; end
        tick(); tick();
        check_reset_outputs("rst");
        map_rst = 1'b0;
        tick();

        // Directed dump, st_rdy tied high
        mem[0] = 8'h05; mem[1] = 8'h12; mem[2] = 8'h1F; mem[IDX] = 8'h22;
        run_dump("dump", 2 * (REG_CNT + 1) + 1, 1'b0);

        // Same dump with back-pressure 1 high / 2 low
        rdy_mode = 1;
        run_dump("dump_bp", 0, 1'b0);
        rdy_mode = 0;

        // Directed restore with matching header
        run_rest("rest", 8'h22, 8'h22, 2 * REG_CNT + 2);
        ld_arr[1] = 8'h0A;

        // Header mismatch
        rdy_cnt = 0;
        run_rest("rest_bad", 8'h21, 8'h22, 2);
        check("rest_bad_rdy_cycles", rdy_cnt, 1);

        // Both commands together, plus a restore request in the middle of the dump
        rdy_cnt = 0;
        st_q.delete(); wr_q.delete();
        start(1'b1, 1'b1);
        check("both_err_clr", err, 1'b0);
        check("both_dump_vld", st_vld, 1'b0);
        tick(); tick();
        cmd_rest = 1'b1;
        tick();
        cmd_rest = 1'b0;
        wait_done(n);
        check("both_len", st_q.size(), REG_CNT + 1);
        check("both_no_rdy", rdy_cnt, 0);
        check("both_no_we", wr_q.size(), 0);
        tick();
        check("both_idle", busy, 1'b0);

        // Reset in R_DATA after one register write
        map_idx_exp = 8'h22;
        ld_arr[0] = 8'h22; ld_arr[1] = 8'h5A;
        wr_q.delete(); consumed = 0; ld_len = 2;
        start(1'b0, 1'b1);
        n = 0;
        while (wr_q.size() < 1 && n < 50) begin tick(); n++; end
        check("mid_one_write", wr_q.size(), 1);
        check("mid_in_rdata", ld_rdy, 1'b1);
        map_rst = 1'b1;
        tick();
        check_reset_outputs("mid_rst");
        map_rst = 1'b0;
        ld_len = 0;
        for (int i = 0; i < 5; i++) tick();
        check("mid_no_more_we", wr_q.size(), 1);
        for (int i = 0; i < REG_CNT; i++) mem[i] = 8'($urandom);
        mem[IDX] = 8'($urandom);
        run_dump("post_rst_dump", 2 * (REG_CNT + 1) + 1, 1'b0);

        // Randomized operations
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < REG_CNT; i++) mem[i] = 8'($urandom);
            mem[IDX] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                rdy_mode = 2;
                run_dump($sformatf("rnd%0d_dump", it), 0, 1'b0);
                rdy_mode = 0;
            end else begin
                logic [7:0] e, h;
                e = 8'($urandom);
                h = ($urandom_range(0, 2) == 0) ? e ^ 8'(1 << $urandom_range(0, 7)) : e;
                vld_rand = 1'b1;
                run_rest($sformatf("rnd%0d_rest", it), h, e, 0);
                vld_rand = 1'b0;
            end
        end

        check("protocol_viol", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
